sr_run_sequencer: RTL and testbench
===================================

// Module: sr_run_sequencer
// PURPOSE
//  Initiator side of the start/stop counter interface. Accepts a run command
//  (valid/ready) and issues one start pulse, then one stop pulse so that the
//  counter is enabled for exactly cmd_len cycles. It then waits for the
//  counter's 2-cycle-delayed stop echo and reports done or an error.
//  Sits between the command source and the mod-14 enable counter.
// PARAMETERS
//  LEN_W         8   width of cmd_len and of the internal run down-counter
//  ECHO_TIMEOUT  4   max cycles spent in ECHO waiting for stop_echo (>=3)
//  COUNT_MOD     14  counter modulus; count values 0..COUNT_MOD-1
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      async, active-high; clears all state
//  cmd_valid     in   1      run command present
//  cmd_ready     out  1      high only in IDLE; accept on valid&&ready
//  cmd_len       in   LEN_W  number of enabled counter cycles (0 treated as 1)
//  start         out  1      one-cycle set pulse to counter
//  stop          out  1      one-cycle clear pulse to counter
//  stop_echo     in   1      counter's stop delayed 2 cycles
//  count_in      in   4      counter value
//  busy          out  1      high in any state other than IDLE
//  done          out  1      one-cycle pulse: run finished cleanly
//  err_timeout   out  1      sticky; set when echo not seen in time
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, cmd_ready=1, start=0, stop=0,
//    busy=0, done=0, err_timeout=0, err_mismatch=0, run counter=0.
//  - FSM: IDLE -> START -> RUN -> STOP -> ECHO -> IDLE.
//  - IDLE: on cmd_valid&&cmd_ready latch len=max(cmd_len,1); next START.
//  - START (1 cycle): start=1; latch base=count_in; load down-counter=len-1.
//  - RUN: decrement each cycle; when counter==0 go STOP (0 RUN cycles if len=1).
//  - STOP (1 cycle): stop=1. start and stop never high together.
//  - Timing: start in cycle 0 => stop in cycle len => counter enabled cycles
//    1..len => exactly len increments; stop_echo expected in cycle len+2.
//  - ECHO: wait for stop_echo; timer counts ECHO cycles. On stop_echo:
//    done=1 for one cycle, -> IDLE. If timer reaches ECHO_TIMEOUT first:
//    err_timeout=1 (sticky until reset), done=0, -> IDLE.
//  - stop_echo seen outside ECHO is ignored. cmd_valid outside IDLE ignored.
//  - Next command may be accepted the cycle after done (IDLE, cmd_ready=1).
//  - Arithmetic: expected = (base + len) mod COUNT_MOD, computed with
//    LEN_W+1 bits, reduced by a registered modulus in START/RUN (no divider
//    in one cycle beyond a compare/subtract per cycle is acceptable).
//  - Reset mid-run: all outputs return to reset values immediately; a
//    partially issued run is abandoned (no stop issued).
// CONFIGURATION
//  SR_SEQ_COUNT_CHECK_EN defined: adds output err_mismatch (1 bit, sticky);
//    when stop_echo is accepted in ECHO, count_in != expected sets it;
//    done still pulses. Undefined: port absent, no base/expected logic.
// TESTING
//  1 reset, cmd_len=5 from count 0 -> start@c0, stop@c5, echo@c7, done@c8,
//    count=5, err_mismatch=0.
//  2 cmd_len=0 -> behaves as len=1: start@c0, stop@c1, final count +1.
//  3 base count 10, cmd_len=6 -> final count 2 (wrap 13->0), no mismatch.
//  4 stop_echo held low -> err_timeout=1 after 4 ECHO cycles, no done,
//    cmd_ready=1 next cycle; err_timeout remains set.
//  5 reset asserted during RUN -> start/stop/busy=0 at once, cmd_ready=1.
//  6 (CHECK_EN) force count_in=3 at echo, expected 5 -> err_mismatch=1, done=1.

Source files
------------

// File: rtl/sr_run_sequencer_if.sv
// sr_run_sequencer_if: command handshake, counter start/stop and status bundle for
// sr_run_sequencer.
//
// Modports:
//   master - the sequencer. It takes in the command and the counter feedback
//            (cmd_valid, cmd_len, stop_echo, count_in). It drives cmd_ready, start,
//            stop, busy, done and err_timeout.
//   slave  - the environment: the command source together with the counter.
//
// Optional feature: define SR_SEQ_COUNT_CHECK_EN to add err_mismatch.
interface sr_run_sequencer_if #(
    parameter int unsigned LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             start;
    logic             stop;
    logic             stop_echo;
    logic [3:0]       count_in;
    logic             busy;
    logic             done;
    logic             err_timeout;
`ifdef SR_SEQ_COUNT_CHECK_EN
    logic             err_mismatch;
`endif

    modport master (
        input  cmd_valid, cmd_len, stop_echo, count_in,
`ifdef SR_SEQ_COUNT_CHECK_EN
        output err_mismatch,
`endif
        output cmd_ready, start, stop, busy, done, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_len, stop_echo, count_in,
`ifdef SR_SEQ_COUNT_CHECK_EN
        input  err_mismatch,
`endif
        input  cmd_ready, start, stop, busy, done, err_timeout
    );
endinterface

// File: rtl/sr_run_sequencer.sv
// sr_run_sequencer: the initiator for a start/stop enable counter.
// The block accepts a run command of cmd_len cycles, where a length of 0 is treated
// as 1. It sends one start pulse, and after cmd_len cycles it sends one stop pulse.
// With this timing the counter is enabled for exactly cmd_len cycles. The block
// then waits for the counter's stop echo, which arrives two cycles after stop. If
// the echo arrives, done pulses. If it does not arrive in time, the sticky
// err_timeout flag is set.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears all state
//   bus    - sr_run_sequencer_if.master (command handshake, start/stop, status)
//
// Optional feature: when SR_SEQ_COUNT_CHECK_EN is defined, the block compares
// count_in at the echo with (base + len) mod COUNT_MOD. On a mismatch it sets
// the sticky err_mismatch flag.
module sr_run_sequencer #(
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned ECHO_TIMEOUT = 4,
    parameter int unsigned COUNT_MOD    = 14
) (
    input logic                 clk,
    input logic                 reset,
    sr_run_sequencer_if.master  bus
);
    localparam int unsigned TmrW = $clog2(ECHO_TIMEOUT + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StEcho  = 3'd4;

    if (ECHO_TIMEOUT < 3 || COUNT_MOD < 2 || COUNT_MOD > 16) begin : g_bad_params
        $error("sr_run_sequencer: ECHO_TIMEOUT must be >= 3 and COUNT_MOD in 2..16");
    end

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic             cmd_ready_q, start_q, stop_q, busy_q, done_q, done_d;
    logic             err_timeout_q, err_timeout_d;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        done_d        = 1'b0;
        err_timeout_d = err_timeout_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    len_d   = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = len_q - LEN_W'(1);
                state_d = (len_q == LEN_W'(1)) ? StStop : StRun;
            end
            StRun: begin
                // Go to STOP when this decrement brings the counter to zero.
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                tmr_d   = '0;
                state_d = StEcho;
            end
            StEcho: begin
                if (bus.stop_echo) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (tmr_q == TmrW'(ECHO_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The outputs are registered decodes of the next state. Because of this,
    // start and stop can never be high at the same time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            len_q         <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            cmd_ready_q   <= 1'b1;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            cmd_ready_q   <= (state_d == StIdle);
            start_q       <= (state_d == StStart);
            stop_q        <= (state_d == StStop);
            busy_q        <= (state_d != StIdle);
            done_q        <= done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.start       = start_q;
    assign bus.stop        = stop_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_timeout = err_timeout_q;

`ifdef SR_SEQ_COUNT_CHECK_EN
    localparam int unsigned ExpW = LEN_W + 1;

    logic [ExpW-1:0] exp_q, exp_d;
    logic            err_mismatch_q, err_mismatch_d;

    // In START, exp is loaded with base + len. After that, it loses one modulus
    // per cycle until it is in range. There are always at least len+1 cycles
    // before the echo can arrive, which is enough for any sum.
    always_comb begin
        exp_d          = exp_q;
        err_mismatch_d = err_mismatch_q;
        if (state_q == StStart) begin
            exp_d = {1'b0, len_q} + ExpW'(bus.count_in);
        end else if (state_q != StIdle && exp_q >= ExpW'(COUNT_MOD)) begin
            exp_d = exp_q - ExpW'(COUNT_MOD);
        end
        if (state_q == StEcho && bus.stop_echo && ExpW'(bus.count_in) != exp_q) begin
            err_mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q          <= '0;
            err_mismatch_q <= 1'b0;
        end else begin
            exp_q          <= exp_d;
            err_mismatch_q <= err_mismatch_d;
        end
    end

    assign bus.err_mismatch = err_mismatch_q;
`endif
endmodule

// File: tb/tb_sr_run_sequencer.sv
// tb_sr_run_sequencer: self-checking bench for sr_run_sequencer.
// The bench also plays the part of the counter. This is a mod-14 counter that is
// enabled from one cycle after start until the cycle of stop. It echoes stop two
// cycles later, and the echo can be delayed, dropped or given a wrong count.
// A reference model works out the expected outputs for each cycle. It does this
// from the run timeline, not from the design's internal state.
module tb_sr_run_sequencer;
    localparam int unsigned LenW   = 8;
    localparam int          EchoTo = 4;
    localparam int          Mod    = 14;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sr_run_sequencer_if #(.LEN_W(LenW)) bus ();

    sr_run_sequencer #(
        .LEN_W       (LenW),
        .ECHO_TIMEOUT(EchoTo),
        .COUNT_MOD   (Mod)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Counter emulation and echo shaping.
    int cnt = 0;
    bit en = 1'b0;
    int echo_at = -1;
    int echo_delay = 0;
    bit drop_echo = 1'b0;
    bit glitch_en = 1'b0;
    int glitch_val = 0;
    bit spurious_en = 1'b0;

    // Reference model: a run started in cycle t0 with length L.
    bit m_active = 1'b0;
    int m_t0 = 0, m_len = 0, m_base = 0;
    bit m_done = 1'b0, m_to = 1'b0, m_mis = 1'b0;

    // Observed pulse times.
    int last_start = -1, last_stop = -1, last_done = -1, done_count = 0, to_rise = -1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model(int n);
        m_done = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_to     = 1'b0;
            m_mis    = 1'b0;
        end else if (!m_active) begin
            if (bus.cmd_valid) begin
                m_active = 1'b1;
                m_t0     = n + 1;
                m_len    = (bus.cmd_len == 0) ? 1 : int'(bus.cmd_len);
            end
        end else begin
            if (n == m_t0) m_base = int'(bus.count_in);
            if (n >= m_t0 + m_len + 1 && n <= m_t0 + m_len + EchoTo && bus.stop_echo) begin
                m_done   = 1'b1;
                m_active = 1'b0;
                if (int'(bus.count_in) != (m_base + m_len) % Mod) m_mis = 1'b1;
            end else if (n == m_t0 + m_len + EchoTo) begin
                m_to     = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic compare();
        chk("cmd_ready", int'(bus.cmd_ready), int'(!m_active));
        chk("busy", int'(bus.busy), int'(m_active));
        chk("start", int'(bus.start), int'(m_active && cyc == m_t0));
        chk("stop", int'(bus.stop), int'(m_active && cyc == m_t0 + m_len));
        chk("done", int'(bus.done), int'(m_done));
        chk("err_timeout", int'(bus.err_timeout), int'(m_to));
`ifdef SR_SEQ_COUNT_CHECK_EN
        chk("err_mismatch", int'(bus.err_mismatch), int'(m_mis));
`endif
        if (bus.start) last_start = cyc;
        if (bus.stop) last_stop = cyc;
        if (bus.done) begin
            last_done = cyc;
            done_count++;
        end
        if (bus.err_timeout && to_rise < 0) to_rise = cyc;
    endtask

    // One clock cycle. At the falling edge, drive the counter side. At the rising
    // edge, step the model. Just after the rising edge, compare.
    task automatic step();
        @(negedge clk);
        bus.stop_echo = (cyc == echo_at) || (spurious_en && $urandom_range(0, 19) == 0);
        bus.count_in  = (glitch_en && cyc == echo_at) ? 4'(glitch_val) : 4'(cnt);
        if (en) cnt = (cnt + 1) % Mod;
        if (bus.start) en = 1'b1;
        else if (bus.stop) en = 1'b0;
        if (bus.stop && !drop_echo) echo_at = cyc + 2 + echo_delay;
        @(posedge clk);
        model(cyc);
        cyc++;
        #1;
        compare();
    endtask

    task automatic run_cmd(int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!m_active) break;
        end
        chk("run_completes", int'(m_active), 0);
    endtask

    initial begin
        int dc;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.stop_echo = 1'b0;
        bus.count_in  = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_start", int'(bus.start), 0);
        chk("rst_stop", int'(bus.stop), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err_timeout", int'(bus.err_timeout), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Length 5 from count 0.
        run_cmd(5);
        chk("t1_stop_after_start", last_stop - last_start, 5);
        chk("t1_echo_after_start", echo_at - last_start, 7);
        chk("t1_done_after_start", last_done - last_start, 8);
        chk("t1_count", cnt, 5);
`ifdef SR_SEQ_COUNT_CHECK_EN
        chk("t1_mismatch", int'(bus.err_mismatch), 0);
`endif
        step();

        // Length 0 is treated as 1.
        run_cmd(0);
        chk("t2_stop_after_start", last_stop - last_start, 1);
        chk("t2_count", cnt, 6);
        step();

        // Wrap from 10 with length 6.
        cnt = 10;
        step();
        run_cmd(6);
        chk("t3_count_wrap", cnt, 2);
`ifdef SR_SEQ_COUNT_CHECK_EN
        chk("t3_mismatch", int'(bus.err_mismatch), 0);
        step();

        // A wrong count at the echo sets err_mismatch, and done still pulses.
        cnt = 0;
        glitch_en = 1'b1;
        glitch_val = 3;
        dc = done_count;
        step();
        run_cmd(5);
        chk("t6_mismatch", int'(bus.err_mismatch), 1);
        chk("t6_done_pulsed", done_count - dc, 1);
        glitch_en = 1'b0;
`endif
        step();

        // No echo: timeout after four ECHO cycles.
        drop_echo = 1'b1;
        dc = done_count;
        run_cmd(3);
        chk("t4_no_done", done_count - dc, 0);
        chk("t4_timeout_cycle", to_rise - last_start, 8);
        chk("t4_ready_after_timeout", int'(bus.cmd_ready), 1);
        step();
        step();
        chk("t4_timeout_sticky", int'(bus.err_timeout), 1);
        drop_echo = 1'b0;

        // Reset in the middle of RUN.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd10;
        step();
        bus.cmd_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("t5_start", int'(bus.start), 0);
        chk("t5_stop", int'(bus.stop), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_cmd_ready", int'(bus.cmd_ready), 1);
        chk("t5_err_timeout", int'(bus.err_timeout), 0);
        en = 1'b0;
        echo_at = -1;
        step();
        step();
        reset = 1'b0;
        step();

        // Random traffic.
        spurious_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 2) != 0);
            bus.cmd_len   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 60))
                                                        : 8'($urandom_range(0, 8));
            echo_delay    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            drop_echo     = ($urandom_range(0, 9) == 0);
            glitch_en     = ($urandom_range(0, 5) == 0);
            glitch_val    = $urandom_range(0, 13);
            step();
        end
        bus.cmd_valid = 1'b0;
        spurious_en = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
